reg_op_sequencer: RTL and testbench

- Multi-cycle operation sequencer that sits directly in front of register_file and is its only client.
- Accepts one register-to-register command at a time over a valid/ready handshake.
- Drives register_file's single read port twice to fetch both operands, computes a 16-bit result, then drives the write port to commit it.
- Serialises the two operand reads because register_file has one read port.

---
 rtl/reg_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_reg_op_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
// Multi-cycle sequencer: fetches two operands over one register_file read port, computes, then writes back.
// Optional zero/carry flag outputs are enabled by defining SEQ_FLAGS_EN.
module reg_op_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int INDEX_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [INDEX_WIDTH-1:0] cmd_dst,
   input  logic [INDEX_WIDTH-1:0] cmd_src_a,
   input  logic [INDEX_WIDTH-1:0] cmd_src_b,
   output logic [INDEX_WIDTH-1:0] read_index_a,
   input  logic [DATA_WIDTH-1:0]  read_data_a,
   output logic [INDEX_WIDTH-1:0] write_index,
   output logic [DATA_WIDTH-1:0]  write_data,
   output logic                   write_enable,
   output logic                   done
`ifdef SEQ_FLAGS_EN
   ,
   output logic                   flag_zero,
   output logic                   flag_carry
`endif
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MOV = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_A,
      S_READ_B,
      S_EXEC,
      S_WRITE
   } state_t;

   state_t                 state;
   logic [1:0]             op_q;
   logic [INDEX_WIDTH-1:0] dst_q;
   logic [INDEX_WIDTH-1:0] src_b_q;
   logic [DATA_WIDTH-1:0]  op_a;
   logic [DATA_WIDTH-1:0]  op_b;
   logic [DATA_WIDTH-1:0]  result;
   logic                   we_q;
   logic                   done_q;
   logic                   accept;
   logic [DATA_WIDTH:0]    alu_out;

   // Top bit carries ADD carry-out or SUB borrow; it is 0 for AND and MOV.
   function automatic logic [DATA_WIDTH:0] alu_calc(
      input logic [1:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH:0] r;
      case (op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {(a < b), a - b};
         OP_AND:  r = {1'b0, a & b};
         default: r = {1'b0, a};
      endcase
      return r;
   endfunction

   assign alu_out      = alu_calc(op_q, op_a, op_b);
   assign cmd_ready    = reset && (state == S_IDLE || state == S_WRITE);
   assign accept       = cmd_valid && cmd_ready;
   assign write_enable = reset && we_q;
   assign done         = reset && done_q;
   assign write_index  = dst_q;
   assign write_data   = result;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         op_q         <= '0;
         dst_q        <= '0;
         src_b_q      <= '0;
         op_a         <= '0;
         op_b         <= '0;
         result       <= '0;
         read_index_a <= '0;
         we_q         <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_WRITE: begin
               we_q   <= 1'b0;
               done_q <= 1'b0;
               if (accept) begin
                  op_q         <= cmd_op;
                  dst_q        <= cmd_dst;
                  src_b_q      <= cmd_src_b;
                  read_index_a <= cmd_src_a;
                  state        <= S_READ_A;
               end else begin
                  read_index_a <= '0;
                  state        <= S_IDLE;
               end
            end
            S_READ_A: begin
               op_a <= read_data_a;
               if (op_q == OP_MOV) begin
                  read_index_a <= '0;
                  state        <= S_EXEC;
               end else begin
                  read_index_a <= src_b_q;
                  state        <= S_READ_B;
               end
            end
            S_READ_B: begin
               op_b         <= read_data_a;
               read_index_a <= '0;
               state        <= S_EXEC;
            end
            S_EXEC: begin
               result <= alu_out[DATA_WIDTH-1:0];
               we_q   <= 1'b1;
               done_q <= 1'b1;
               state  <= S_WRITE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef SEQ_FLAGS_EN
   // Flags change only when leaving EXEC, so they stay valid through WRITE and beyond.
   always_ff @(posedge clk) begin
      if (!reset) begin
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
      end else if (state == S_EXEC) begin
         flag_zero  <= (alu_out[DATA_WIDTH-1:0] == '0);
         flag_carry <= alu_out[DATA_WIDTH];
      end
   end
`else
   logic unused_carry;
   assign unused_carry = alu_out[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural register_file model.
module tb_reg_op_sequencer;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [1:0]  cmd_dst;
   logic [1:0]  cmd_src_a;
   logic [1:0]  cmd_src_b;
   logic [1:0]  read_index_a;
   logic [15:0] read_data_a;
   logic [1:0]  write_index;
   logic [15:0] write_data;
   logic        write_enable;
   logic        done;
`ifdef SEQ_FLAGS_EN
   logic        flag_zero;
   logic        flag_carry;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] rf [4] = '{16'd3, 16'd7, 16'd0, 16'hFFFF};
   logic        pl_en  = 1'b0;
   logic [1:0]  pl_idx = 2'd0;
   logic [15:0] pl_val = 16'd0;

   reg_op_sequencer #(.DATA_WIDTH(16), .INDEX_WIDTH(2)) dut (
      .clk(clk),
      .reset(reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_dst(cmd_dst),
      .cmd_src_a(cmd_src_a),
      .cmd_src_b(cmd_src_b),
      .read_index_a(read_index_a),
      .read_data_a(read_data_a),
      .write_index(write_index),
      .write_data(write_data),
      .write_enable(write_enable),
      .done(done)
`ifdef SEQ_FLAGS_EN
      ,
      .flag_zero(flag_zero),
      .flag_carry(flag_carry)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign read_data_a = rf[read_index_a];

   always @(posedge clk) begin
      if (write_enable) rf[write_index] <= write_data;
      else if (pl_en)   rf[pl_idx] <= pl_val;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic preload(input logic [1:0] idx, input logic [15:0] val);
      @(negedge clk);
      pl_en  = 1'b1;
      pl_idx = idx;
      pl_val = val;
      @(negedge clk);
      pl_en  = 1'b0;
   endtask

   task automatic set_cmd(input logic [1:0] op, input logic [1:0] dst,
                          input logic [1:0] a, input logic [1:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_dst   = dst;
      cmd_src_a = a;
      cmd_src_b = b;
   endtask

   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [1:0] dst,
                          input logic [1:0] a, input logic [1:0] b, input logic [15:0] exp_data,
                          input int exp_lat, input logic exp_z, input logic exp_c);
      int          we_cnt;
      int          done_cnt;
      int          we_k;
      logic [1:0]  wi;
      logic [15:0] wd;
      we_cnt = 0; done_cnt = 0; we_k = 0; wi = '0; wd = '0;
      @(negedge clk);
      set_cmd(op, dst, a, b);
      check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (write_enable) begin
            we_cnt++;
            we_k = k;
            wi   = write_index;
            wd   = write_data;
`ifdef SEQ_FLAGS_EN
            check({tag, "_fz"}, {31'd0, flag_zero}, {31'd0, exp_z});
            check({tag, "_fc"}, {31'd0, flag_carry}, {31'd0, exp_c});
`endif
         end
      end
      check({tag, "_we_cnt"}, we_cnt, 1);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_lat"}, we_k, exp_lat);
      check({tag, "_widx"}, {30'd0, wi}, {30'd0, dst});
      check({tag, "_wdata"}, {16'd0, wd}, {16'd0, exp_data});
      check({tag, "_rf"}, {16'd0, rf[dst]}, {16'd0, exp_data});
   endtask

   initial begin
      int we_cnt;
      int done_cnt;
      reset = 1'b0;
      set_cmd(2'b00, 2'd2, 2'd0, 2'd1);

      // Reset held with a command offered
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("rst_ready", {31'd0, cmd_ready}, 32'd0);
         check("rst_we", {31'd0, write_enable}, 32'd0);
         check("rst_done", {31'd0, done}, 32'd0);
      end
      check("rst_ridx", {30'd0, read_index_a}, 32'd0);
      check("rst_widx", {30'd0, write_index}, 32'd0);
      check("rst_wdata", {16'd0, write_data}, 32'd0);
      reset = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("post_rst_r2", {16'd0, rf[2]}, 32'd0);

      run_cmd("add", 2'b00, 2'd2, 2'd0, 2'd1, 16'd10, 4, 1'b0, 1'b0);
      run_cmd("sub", 2'b01, 2'd1, 2'd0, 2'd1, 16'hFFFC, 4, 1'b0, 1'b1);
      preload(2'd0, 16'd1);
      run_cmd("add_wrap", 2'b00, 2'd0, 2'd3, 2'd0, 16'h0000, 4, 1'b1, 1'b1);

      // Back-to-back ADD then MOV accepted during WRITE
      preload(2'd0, 16'd3);
      preload(2'd1, 16'd7);
      @(negedge clk);
      set_cmd(2'b00, 2'd2, 2'd0, 2'd1);
      @(posedge clk);
      #1 set_cmd(2'b11, 2'd3, 2'd2, 2'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("b2b_ready", {31'd0, cmd_ready}, (k == 4) ? 32'd1 : 32'd0);
      end
      check("b2b_add_we", {31'd0, write_enable}, 32'd1);
      check("b2b_add_widx", {30'd0, write_index}, 32'd2);
      check("b2b_add_wdata", {16'd0, write_data}, 32'd10);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      we_cnt = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) check("b2b_mov_ridx", {30'd0, read_index_a}, 32'd2);
         if (write_enable) begin
            we_cnt++;
            check("b2b_mov_lat", k, 3);
            check("b2b_mov_widx", {30'd0, write_index}, 32'd3);
            check("b2b_mov_wdata", {16'd0, write_data}, 32'd10);
         end
      end
      check("b2b_mov_we_cnt", we_cnt, 1);
      check("b2b_r3", {16'd0, rf[3]}, 32'd10);

      run_cmd("and", 2'b10, 2'd1, 2'd0, 2'd3, 16'd2, 4, 1'b0, 1'b0);

      // Reset during EXEC of AND R2=R0&R1 abandons the command
      @(negedge clk);
      set_cmd(2'b10, 2'd2, 2'd0, 2'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      we_cnt = 0;
      done_cnt = 0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (write_enable) we_cnt++;
         if (done) done_cnt++;
      end
      reset = 1'b0;
      @(negedge clk);
      check("exec_rst_ready", {31'd0, cmd_ready}, 32'd0);
      if (write_enable) we_cnt++;
      if (done) done_cnt++;
      reset = 1'b1;
      @(negedge clk);
      check("exec_rst_idle", {31'd0, cmd_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         if (write_enable) we_cnt++;
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("exec_rst_we", we_cnt, 0);
      check("exec_rst_done", done_cnt, 0);
      check("exec_rst_r2", {16'd0, rf[2]}, 32'd10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
